// File: rtl/alu_issue_if.sv
// Decode / register-file / ALU / writeback signal bundle for alu_issue.
// slave is the issue stage itself; master is the surrounding core (or bench).
interface alu_issue_if #(parameter int XLEN = 64);
  logic            instr_valid;
  logic [31:0]     instr;
  logic            instr_ready;
  logic [4:0]      rs1_addr, rs2_addr;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic [31:0]     alu_instruction;
  logic [XLEN-1:0] alu_in1, alu_in2;
  logic [XLEN-1:0] alu_out;
  logic            wb_valid;
  logic            wb_ready;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            err_illegal;

  modport slave (
    input  instr_valid, instr, rs1_data, rs2_data, alu_out, wb_ready,
    output instr_ready, rs1_addr, rs2_addr, alu_instruction, alu_in1, alu_in2,
           wb_valid, wb_rd, wb_data, err_illegal
  );

  modport master (
    output instr_valid, instr, rs1_data, rs2_data, alu_out, wb_ready,
    input  instr_ready, rs1_addr, rs2_addr, alu_instruction, alu_in1, alu_in2,
           wb_valid, wb_rd, wb_data, err_illegal
  );
endinterface

// File: rtl/alu_issue.sv
// Two-slot operand-issue / result-capture stage in front of the RV64 ALU.
// ALU_ISSUE_FWD_EN: defined -> S1/S2 forwarding; undefined -> RAW interlock on instr_ready.
module alu_issue #(
  parameter int XLEN = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_issue_if.slave  bus
);
  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;

  typedef struct packed {
    logic [31:0]     ins;
    logic [XLEN-1:0] in1;
    logic [XLEN-1:0] in2;
    logic [4:0]      rd;
  } s1_t;

  s1_t             s1;
  logic            s1_valid;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            err;

  logic [6:0]      opc;
  logic [2:0]      funct3;
  logic [4:0]      rs1, rs2, rd;
  logic            is_op, is_imm, legal;
  logic            s2_take, s2_load, s1_adv, hazard, accept;
  logic [XLEN-1:0] src1, src2, op2;
  logic [6:0]      f7;

  assign opc    = bus.instr[6:0];
  assign rd     = bus.instr[11:7];
  assign funct3 = bus.instr[14:12];
  assign rs1    = bus.instr[19:15];
  assign rs2    = bus.instr[24:20];
  assign is_op  = (opc == OPC_OP);
  assign is_imm = (opc == OPC_IMM);
  assign legal  = is_op | is_imm;

  assign bus.rs1_addr = rs1;
  assign bus.rs2_addr = rs2;

  assign s2_take = !wb_valid || bus.wb_ready;
  assign s2_load = s1_valid && (s1.rd != 5'd0) && s2_take;
  assign s1_adv  = s1_valid && (s2_take || (s1.rd == 5'd0));
  assign bus.instr_ready = (!s1_valid || s1_adv) && !hazard;
  assign accept  = bus.instr_valid && bus.instr_ready;

`ifdef ALU_ISSUE_FWD_EN
  // S1 result is still on alu_out; S2 is written to the register file at this same edge.
  function automatic logic [XLEN-1:0] fwd(input logic [4:0] n, input logic [XLEN-1:0] rf,
                                          input logic s1v, input logic [4:0] s1rd,
                                          input logic [XLEN-1:0] s1res, input logic s2v,
                                          input logic [4:0] s2rd, input logic [XLEN-1:0] s2res);
    if (n == 5'd0)                return '0;
    else if (s1v && s1rd == n)    return s1res;
    else if (s2v && s2rd == n)    return s2res;
    else                          return rf;
  endfunction

  assign hazard = 1'b0;
  assign src1 = fwd(rs1, bus.rs1_data, s1_valid, s1.rd, bus.alu_out, wb_valid, wb_rd, wb_data);
  assign src2 = fwd(rs2, bus.rs2_data, s1_valid, s1.rd, bus.alu_out, wb_valid, wb_rd, wb_data);
`else
  function automatic logic hit(input logic [4:0] n, input logic s1v, input logic [4:0] s1rd,
                               input logic s2v, input logic [4:0] s2rd);
    return (n != 5'd0) && ((s1v && s1rd == n) || (s2v && s2rd == n));
  endfunction

  // Hold the offered instruction until every in-flight producer of its sources has retired.
  assign hazard = (legal && hit(rs1, s1_valid, s1.rd, wb_valid, wb_rd)) ||
                  (is_op && hit(rs2, s1_valid, s1.rd, wb_valid, wb_rd));
  assign src1 = (rs1 == 5'd0) ? '0 : bus.rs1_data;
  assign src2 = (rs2 == 5'd0) ? '0 : bus.rs2_data;
`endif

  // OP-IMM: shifts take a 6-bit shamt; only SRAI may carry funct7 = 0x20.
  always_comb begin
    op2 = src2;
    f7  = bus.instr[31:25];
    if (is_imm) begin
      f7  = 7'h00;
      op2 = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};
      if (funct3 == 3'd1 || funct3 == 3'd5) op2 = {{(XLEN-6){1'b0}}, bus.instr[25:20]};
      if (funct3 == 3'd5 && bus.instr[30])  f7  = 7'h20;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= '0;
      s1_valid <= 1'b0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      err      <= 1'b0;
    end else begin
      err <= accept && !legal;
      if (!s1_valid || s1_adv) s1_valid <= accept && legal;
      if (accept && legal) begin
        s1.ins <= {f7, bus.instr[24:0]};
        s1.in1 <= src1;
        s1.in2 <= op2;
        s1.rd  <= rd;
      end
      if (s2_load) begin
        wb_valid <= 1'b1;
        wb_rd    <= s1.rd;
        wb_data  <= bus.alu_out;
      end else if (bus.wb_ready) begin
        wb_valid <= 1'b0;
      end
    end
  end

  assign bus.alu_instruction = s1.ins;
  assign bus.alu_in1         = s1.in1;
  assign bus.alu_in2         = s1.in2;
  assign bus.wb_valid        = wb_valid;
  assign bus.wb_rd           = wb_rd;
  assign bus.wb_data         = wb_data;
  assign bus.err_illegal     = err;
endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: reference regfile + ALU around the DUT, scoreboard on writeback.
`timescale 1ns/1ps
module tb_alu_issue;
  localparam int XLEN = 64;
  localparam logic [6:0] OPI = 7'b0010011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_if #(.XLEN(XLEN)) bus ();
  alu_issue #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed { logic [4:0] rd; logic [XLEN-1:0] data; } wb_t;
  wb_t             sb[$];
  wb_t             exp_e;
  int              n_vec = 0;
  int              n_err = 0;
  int              w;
  logic [XLEN-1:0] regs [32];
  logic [5:0]      sh;

  assign bus.rs1_data = (bus.rs1_addr == 5'd0) ? '0 : regs[bus.rs1_addr];
  assign bus.rs2_data = (bus.rs2_addr == 5'd0) ? '0 : regs[bus.rs2_addr];
  assign sh = bus.alu_in2[5:0];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (bus.wb_valid && bus.wb_ready && bus.wb_rd != 5'd0) begin
      regs[bus.wb_rd] <= bus.wb_data;
    end
  end

  // Reference RV64 ALU decoding funct3 / funct7[5] of the sanitised word.
  always_comb begin
    bus.alu_out = '0;
    case (bus.alu_instruction[14:12])
      3'd0: if (bus.alu_instruction[30]) bus.alu_out = bus.alu_in1 - bus.alu_in2;
            else                         bus.alu_out = bus.alu_in1 + bus.alu_in2;
      3'd1: bus.alu_out = bus.alu_in1 << sh;
      3'd2: bus.alu_out = {{(XLEN-1){1'b0}}, $signed(bus.alu_in1) < $signed(bus.alu_in2)};
      3'd3: bus.alu_out = {{(XLEN-1){1'b0}}, bus.alu_in1 < bus.alu_in2};
      3'd4: bus.alu_out = bus.alu_in1 ^ bus.alu_in2;
      3'd5: if (bus.alu_instruction[30]) bus.alu_out = $signed(bus.alu_in1) >>> sh;
            else                         bus.alu_out = bus.alu_in1 >> sh;
      3'd6: bus.alu_out = bus.alu_in1 | bus.alu_in2;
      default: bus.alu_out = bus.alu_in1 & bus.alu_in2;
    endcase
  end

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.wb_valid && bus.wb_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL wb_unexpected: got rd %0d data %h, expected no writeback", bus.wb_rd, bus.wb_data);
      end else begin
        exp_e = sb.pop_front();
        chk("wb_rd", 64'(bus.wb_rd), 64'(exp_e.rd));
        chk("wb_data", bus.wb_data, exp_e.data);
      end
    end
  end

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  // Offer one instruction; returns #1 after the accepting edge with waits = stalled cycles.
  task automatic issue(input logic [31:0] ins, input logic exp_wb, input logic [4:0] rd,
                       input logic [XLEN-1:0] data, output int waits);
    waits = 0;
    bus.instr = ins;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    while (!bus.instr_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!bus.instr_ready) begin
      n_vec++;
      n_err++;
      bus.instr_valid = 1'b0;
      $display("FAIL accept_timeout: instr %h not accepted, expected acceptance", ins);
    end else if (exp_wb) begin
      sb.push_back({rd, data});
    end
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1);
  end

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    bus.wb_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("rst_err", 64'(bus.err_illegal), 64'd0);
    chk("rst_alu_ins", 64'(bus.alu_instruction), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(bus.instr_ready), 64'd1);
    @(posedge clk); #1;

    // ADDI x1,x0,-5: sign-extended immediate, two-edge latency
    issue(enc_i(12'hFFB, 5'd0, 3'd0, 5'd1, OPI), 1'b1, 5'd1, 64'hFFFF_FFFF_FFFF_FFFB, w);
    chk("addi_f7", 64'(bus.alu_instruction[31:25]), 64'h0);
    chk("addi_in1", bus.alu_in1, 64'h0);
    chk("addi_in2", bus.alu_in2, 64'hFFFF_FFFF_FFFF_FFFB);
    @(posedge clk); #1;
    chk("lat_wb_valid", 64'(bus.wb_valid), 64'd1);
    chk("lat_wb_rd", 64'(bus.wb_rd), 64'd1);
    chk("lat_wb_data", bus.wb_data, 64'hFFFF_FFFF_FFFF_FFFB);

    // x1 = 1 << 63, then SRAI / SRLI by 4
    issue(enc_i(12'h001, 5'd0, 3'd0, 5'd1, OPI), 1'b1, 5'd1, 64'h1, w);
    issue(enc_i(12'h03F, 5'd1, 3'd1, 5'd1, OPI), 1'b1, 5'd1, 64'h8000_0000_0000_0000, w);
    chk("slli_in1", bus.alu_in1, 64'h1);
    chk("slli_in2", bus.alu_in2, 64'd63);
    issue(enc_i(12'h404, 5'd1, 3'd5, 5'd2, OPI), 1'b1, 5'd2, 64'hF800_0000_0000_0000, w);
    chk("srai_f7", 64'(bus.alu_instruction[31:25]), 64'h20);
    chk("srai_in1", bus.alu_in1, 64'h8000_0000_0000_0000);
    chk("srai_in2", bus.alu_in2, 64'd4);
    issue(enc_i(12'h004, 5'd1, 3'd5, 5'd6, OPI), 1'b1, 5'd6, 64'h0800_0000_0000_0000, w);
    chk("srli_f7", 64'(bus.alu_instruction[31:25]), 64'h0);

    // ADDI with instr[30] set must still add
    issue(enc_i(12'h400, 5'd0, 3'd0, 5'd5, OPI), 1'b1, 5'd5, 64'd1024, w);
    chk("addi30_f7", 64'(bus.alu_instruction[31:25]), 64'h0);
    chk("addi30_in2", bus.alu_in2, 64'd1024);

    // ADDI x3,x0,7 ; ADD x4,x3,x3 ; SUB x11,x3,x4
    issue(enc_i(12'h007, 5'd0, 3'd0, 5'd3, OPI), 1'b1, 5'd3, 64'd7, w);
    issue(enc_r(7'h00, 5'd3, 5'd3, 3'd0, 5'd4), 1'b1, 5'd4, 64'd14, w);
`ifdef ALU_ISSUE_FWD_EN
    chk("raw_stall_cycles", 64'(w), 64'd0);
`else
    chk("raw_interlock", 64'(w > 0), 64'd1);
`endif
    issue(enc_r(7'h20, 5'd4, 5'd3, 3'd0, 5'd11), 1'b1, 5'd11, 64'hFFFF_FFFF_FFFF_FFF9, w);
    chk("sub_f7", 64'(bus.alu_instruction[31:25]), 64'h20);

    // Backpressure: S2 = x7, S1 = x8, x9 offered and held off
    repeat (4) @(posedge clk); #1;
    bus.wb_ready = 1'b0;
    issue(enc_i(12'h001, 5'd0, 3'd0, 5'd7, OPI), 1'b1, 5'd7, 64'd1, w);
    issue(enc_i(12'h002, 5'd0, 3'd0, 5'd8, OPI), 1'b1, 5'd8, 64'd2, w);
    bus.instr = enc_i(12'h003, 5'd0, 3'd0, 5'd9, OPI);
    bus.instr_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_ready", 64'(bus.instr_ready), 64'd0);
      chk("bp_wb_valid", 64'(bus.wb_valid), 64'd1);
      chk("bp_wb_rd", 64'(bus.wb_rd), 64'd7);
      chk("bp_wb_data", bus.wb_data, 64'd1);
    end
    @(posedge clk); #1;
    bus.wb_ready = 1'b1;
    issue(enc_i(12'h003, 5'd0, 3'd0, 5'd9, OPI), 1'b1, 5'd9, 64'd3, w);

    // LW is dropped with a one-cycle error pulse
    repeat (4) @(posedge clk); #1;
    issue(enc_i(12'h000, 5'd0, 3'd2, 5'd10, 7'b0000011), 1'b0, 5'd10, 64'd0, w);
    chk("lw_err", 64'(bus.err_illegal), 64'd1);
    chk("lw_wb_valid", 64'(bus.wb_valid), 64'd0);
    @(posedge clk); #1;
    chk("lw_err_pulse", 64'(bus.err_illegal), 64'd0);
    chk("lw_wb_valid2", 64'(bus.wb_valid), 64'd0);

    // ADD x0,x1,x2 executes but never writes back
    issue(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd0), 1'b0, 5'd0, 64'd0, w);
    @(posedge clk); #1;
    chk("x0_wb_valid", 64'(bus.wb_valid), 64'd0);
    @(posedge clk); #1;
    chk("x0_wb_valid2", 64'(bus.wb_valid), 64'd0);

    // Reset with both slots full
    bus.wb_ready = 1'b0;
    issue(enc_i(12'h005, 5'd0, 3'd0, 5'd12, OPI), 1'b1, 5'd12, 64'd5, w);
    issue(enc_i(12'h006, 5'd0, 3'd0, 5'd13, OPI), 1'b1, 5'd13, 64'd6, w);
    chk("pre_rst_wb_valid", 64'(bus.wb_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("mid_rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("mid_rst_wb_rd", 64'(bus.wb_rd), 64'd0);
    chk("mid_rst_wb_data", bus.wb_data, 64'd0);
    chk("mid_rst_alu_ins", 64'(bus.alu_instruction), 64'd0);
    chk("mid_rst_in1", bus.alu_in1, 64'd0);
    chk("mid_rst_in2", bus.alu_in2, 64'd0);
    chk("mid_rst_err", 64'(bus.err_illegal), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.wb_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(bus.instr_ready), 64'd1);
    chk("post_rst_wb_valid", 64'(bus.wb_valid), 64'd0);

    repeat (3) @(posedge clk); #1;
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_issue.md
# alu_issue

Operand-issue and result-capture stage that drives the 64-bit RV64 integer ALU from the other side: it accepts decoded OP / OP-IMM instructions over a valid/ready handshake, reads the register file, builds the ALU-facing instruction word and operands, captures the ALU result and presents it to writeback. It sits between decode and the register-file write port in the sequential core and is the sole initiator of ALU operations. It is a two-entry pipeline (issue slot S1, writeback slot S2) with full backpressure and result forwarding.

## Interface
- XLEN, 64, operand/result width; must match the ALU.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  decode offers an instruction.
- instr  in  32  RV64I instruction word.
- instr_ready  out  1  instruction accepted on rising edge when instr_valid && instr_ready.
- rs1_addr, rs2_addr  out  5 each  register-file read addresses; combinational from instr[19:15], instr[24:20].
- rs1_data, rs2_data  in  XLEN each  combinational register-file read data.
- alu_instruction  out  32  sanitised instruction word to the ALU (from S1).
- alu_in1, alu_in2  out  XLEN each  ALU operands (from S1).
- alu_out  in  XLEN  combinational ALU result.
- wb_valid  out  1  S2 holds a result.
- wb_ready  in  1  writeback consumes S2 on rising edge when wb_valid && wb_ready.
- wb_rd  out  5  destination register.
- wb_data  out  XLEN  result.
- err_illegal  out  1  one-cycle pulse: unsupported opcode accepted and dropped.

## Operation
- Supported opcodes: 0110011 (OP), 0010011 (OP-IMM). Any other opcode is accepted (consumes the handshake), dropped, and err_illegal is high in the following cycle.
- Operand build at acceptance, captured into S1: in1 = forwarded rs1 value; OP: in2 = forwarded rs2; OP-IMM: in2 = sign-extended instr[31:20], except funct3 1/5 where in2 = zero-extended instr[25:20].
- alu_instruction = instr with funct3 kept; funct7 field rewritten: OP keeps instr[31:25]; OP-IMM sets funct7 = 7'h00 except funct3 5 with instr[30]=1 (SRAI) -> 7'h20. ADDI never yields subtract.
- Source x0 always reads 0, never forwarded.
- Forwarding priority for source n != 0: S1 valid && S1.rd == n -> alu_out; else S2 valid && S2.rd == n -> wb_data; else rsN_data.
- rd = x0: instruction executes but S1 -> S2 transfer is suppressed; no wb_valid.
- S2 advance: S2 loads alu_out and S1.rd when S1 valid, S1.rd != 0, and (!wb_valid || wb_ready).
- S1 advance: S1 empties/reloads when S2 can take it or S1.rd == 0.
- instr_ready = !S1.valid || S1 advancing (ANDed with interlock condition, see Configuration).
- Throughput 1 instruction/cycle with wb_ready held high.

## Timing
- Reset (async assert, sync deassert at use): S1/S2 valid = 0; wb_valid, err_illegal, wb_rd, wb_data, alu_instruction, alu_in1, alu_in2 = 0; instr_ready = 1 after reset.
- Latency: accept at edge k -> ALU sees operands cycle k+1 -> wb_valid high from edge k+1 onward (2-edge path, 1 cycle in S1).
- wb_valid && !wb_ready: S2 holds wb_rd/wb_data stable; S1 holds; instr_ready = 0 if S1 full.
- Simultaneous wb handshake and new S2 load: allowed, no bubble.
- Forwarding from S2 applies in its handshake cycle (register file written at that same edge).
- Reset mid-operation discards both slots; no partial writeback.

## Configuration
- ALU_ISSUE_FWD_EN defined: forwarding as above, no hazard stalls.
- Undefined: no forwarding; instr_ready additionally deasserted while any nonzero source of the offered instr matches rd of a valid S1 or S2 entry (interlock until drained); operands always from rsN_data.

## Test plan
- Reset: rst_n low mid-stream with S1/S2 full -> all outputs 0, wb_valid 0; instr_ready = 1 on first cycle after release.
- ADDI x1,x0,-5 -> alu_instruction funct7 = 0, alu_in2 = 0xFFFF_FFFF_FFFF_FFFB; wb_rd=1, wb_data = 0xFFFF_FFFF_FFFF_FFFB two edges after accept.
- SRAI x2,x1,4 with x1 = 0x8000_0000_0000_0000 -> funct7 = 0x20, alu_in2 = 4, wb_data = 0xF800_0000_0000_0000.
- Back-to-back ADDI x3,x0,7; ADD x4,x3,x3 (FWD_EN) -> no stall, second wb_data = 14; without macro -> instr_ready low until x3 drains, same result.
- wb_ready low 3 cycles with 3 instructions offered -> S1, S2 hold, instr_ready low, results delivered in order with no loss or duplication.
- LW opcode offered -> accepted, err_illegal pulses 1 cycle, no wb_valid; ADD x0,x1,x2 -> no wb_valid.
